mult_div_unit: RTL and testbench

//   Execute-stage multiply/divide unit (MDU); consumes the mult/div control and operands

---
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Execute-stage multiply/divide unit. Runs multi-cycle
//            MULT/MULTU/DIV/DIVU, performs MTHI/MTLO in one cycle, and holds
//            the HI/LO architectural registers. busy/stall let the hazard
//            unit hold MFHI/MFLO/MDU instructions in D until results commit.
// Ports    : clk          in   1   clock, rising edge
//            reset        in   1   asynchronous active-low reset
//            start        in   1   MDU op valid in E this cycle
//            mult_div_op  in   3   0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO
//                                  6 MADD 7 MADDU (only with MDU_MADD_EN)
//            A, B         in   32  forwarded rs / rt operands
//            busy         out  1   multi-cycle op in flight
//            stall        out  1   start | busy
//            HI, LO       out  32  HI / LO registers
// Config   : `define MDU_MADD_EN enables MADD/MADDU (64-bit accumulate into
//            HI/LO); without it ops 6/7 are no-ops and no adder is built.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mult_div_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] c_op_madd  = 3'd6;
    localparam logic [2:0] c_op_maddu = 3'd7;
`endif

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [63:0] r_temp, w_temp_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;

    // Signed and unsigned ops differ only in bit 0 of the opcode (even =
    // signed), so one multiplier and one divider serve both flavours.
    logic        w_signed;
    logic [63:0] w_ma, w_mb, w_prod;
    logic [31:0] w_dvd, w_dvs, w_q_mag, w_r_mag, w_quo, w_rem;
    logic        w_b_zero;

    always_comb begin
        w_signed = ~mult_div_op[0];

        // Low 64 bits of a 64x64 product of extended operands equal the
        // exact signed/unsigned 32x32 product.
        w_ma   = {{32{w_signed & A[31]}}, A};
        w_mb   = {{32{w_signed & B[31]}}, B};
        w_prod = w_ma * w_mb;

        // Signed divide on magnitudes, then restore signs: quotient negative
        // when operand signs differ, remainder takes the dividend's sign.
        // 0x80000000 / -1 falls out naturally as LO=0x80000000, HI=0.
        w_b_zero = (B == 32'd0);
        w_dvd    = (w_signed & A[31]) ? (32'd0 - A) : A;
        w_dvs    = (w_signed & B[31]) ? (32'd0 - B) : B;
        if (w_b_zero) begin
            w_dvs = 32'd1;
        end
        w_q_mag  = w_dvd / w_dvs;
        w_r_mag  = w_dvd % w_dvs;
        w_quo    = (w_signed & (A[31] ^ B[31])) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem    = (w_signed & A[31]) ? (32'd0 - w_r_mag) : w_r_mag;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_temp_nxt  = r_temp;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (mult_div_op)
                        c_op_mult, c_op_multu: begin
                            w_temp_nxt  = w_prod;
                            w_cnt_nxt   = c_mult_cnt;
                            w_state_nxt = S_RUN;
                        end
                        c_op_div, c_op_divu: begin
                            // Divide by zero still takes the full latency but
                            // commits the current HI/LO, i.e. no change.
                            w_temp_nxt  = w_b_zero ? {r_hi, r_lo} : {w_rem, w_quo};
                            w_cnt_nxt   = c_div_cnt;
                            w_state_nxt = S_RUN;
                        end
                        c_op_mthi: w_hi_nxt = A;
                        c_op_mtlo: w_lo_nxt = A;
`ifdef MDU_MADD_EN
                        c_op_madd, c_op_maddu: begin
                            w_temp_nxt  = {r_hi, r_lo} + w_prod;
                            w_cnt_nxt   = c_mult_cnt;
                            w_state_nxt = S_RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // start is ignored here; HI/LO cannot change before commit,
                // so the captured temp stays valid.
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_hi_nxt    = r_temp[63:32];
                    w_lo_nxt    = r_temp[31:0];
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_temp  <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_temp  <= w_temp_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    assign busy  = (r_state == S_RUN);
    assign stall = start | busy;
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Self-checking bench for mult_div_unit. A behavioural model of
//            HI/LO (plain 64-bit arithmetic) predicts results and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mult_div_op;
    logic [31:0] A, B;
    logic        busy, stall;
    logic [31:0] HI, LO;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_hi, m_lo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .mult_div_op(mult_div_op),
        .A(A), .B(B), .busy(busy), .stall(stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Reference model: updates m_hi/m_lo and returns the expected busy length.
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int ecyc);
        longint      sa, sb, q, r, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ecyc = 0;
        case (op)
            3'd0: begin p = sa * sb; {m_hi, m_lo} = 64'(p); ecyc = MC; end
            3'd1: begin pu = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = pu; ecyc = MC; end
            3'd2: begin
                if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = 32'(q); m_hi = 32'(r); end
                ecyc = DC;
            end
            3'd3: begin
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                ecyc = DC;
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
`ifdef MDU_MADD_EN
            3'd6: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + 64'(p); ecyc = MC; end
            3'd7: begin pu = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = {m_hi, m_lo} + pu; ecyc = MC; end
`endif
            default: ;
        endcase
    endtask

    // Drive one op, return busy length (bounded) and stall seen while start=1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int cyc, output logic st);
        @(negedge clk);
        mult_div_op = op; A = a; B = b; start = 1'b1;
        #1 st = stall;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; mult_div_op = 3'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || stall !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            fails++;
            $display("FAIL reset: busy=%b stall=%b HI=%h LO=%h, expected 0 0 0 0", busy, stall, HI, LO);
        end
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_vectors;
        logic [2:0]  ops [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2};
        logic [31:0] as  [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7,
                                 32'h12345678, 32'h9ABCDEF0, 32'h80000000};
        logic [31:0] bs  [7] = '{32'd3, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic [31:0] eh  [7] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h12345678, 32'h12345678, 32'h00000000};
        logic [31:0] el  [7] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFD,
                                 32'hFFFFFFFD, 32'h9ABCDEF0, 32'h80000000};
        int          ec  [7] = '{MC, MC, DC, DC, 0, 0, DC};
        int          cyc, mc;
        logic        st;
        for (int i = 0; i < 7; i++) begin
            model(ops[i], as[i], bs[i], mc);
            issue(ops[i], as[i], bs[i], cyc, st);
            tests++;
            if (cyc !== ec[i] || st !== 1'b1) begin
                fails++;
                $display("FAIL vec%0d_timing: busy_cycles=%0d stall=%b, expected %0d 1", i, cyc, st, ec[i]);
            end
            tests++;
            if (HI !== eh[i] || LO !== el[i]) begin
                fails++;
                $display("FAIL vec%0d_result: HI=%h LO=%h, expected HI=%h LO=%h", i, HI, LO, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          cyc, ecyc;
        logic        st;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            model(op, a, b, ecyc);
            issue(op, a, b, cyc, st);
            tests++;
            if (cyc !== ecyc || HI !== m_hi || LO !== m_lo || st !== 1'b1) begin
                fails++;
                $display("FAIL random%0d op=%0d A=%h B=%h: cyc=%0d HI=%h LO=%h stall=%b, expected cyc=%0d HI=%h LO=%h stall=1",
                         i, op, a, b, cyc, HI, LO, st, ecyc, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int ecyc, cyc;
        model(3'd2, 32'd100, 32'd7, ecyc);
        @(negedge clk);
        mult_div_op = 3'd2; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (cyc == 3 || cyc == 6) begin
                start = 1'b1;
                mult_div_op = (cyc == 3) ? 3'd4 : 3'd0;
                A = 32'hDEADBEEF; B = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (cyc !== ecyc || HI !== m_hi || LO !== m_lo) begin
            fails++;
            $display("FAIL start_while_busy: cyc=%0d HI=%h LO=%h, expected cyc=%0d HI=%h LO=%h",
                     cyc, HI, LO, ecyc, m_hi, m_lo);
        end
        repeat (8) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            fails++;
            $display("FAIL ignored_start_late: busy=%b HI=%h LO=%h, expected 0 %h %h", busy, HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid_run;
        int   cyc, ecyc;
        logic st;
        model(3'd4, 32'hCAFEF00D, 32'd0, ecyc);
        issue(3'd4, 32'hCAFEF00D, 32'd0, cyc, st);
        model(3'd5, 32'h0BADBEEF, 32'd0, ecyc);
        issue(3'd5, 32'h0BADBEEF, 32'd0, cyc, st);
        @(negedge clk);
        mult_div_op = 3'd2; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 4) begin cyc++; @(negedge clk); end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_run_busy: busy=%b, expected 1", busy);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            fails++;
            $display("FAIL async_abort: busy=%b HI=%h LO=%h, expected 0 0 0", busy, HI, LO);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (15) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            fails++;
            $display("FAIL no_commit_after_reset: busy=%b HI=%h LO=%h, expected 0 0 0", busy, HI, LO);
        end
    endtask

    task automatic test_madd;
        int   cyc, ecyc;
        logic st;
        model(3'd4, 32'd0, 32'd0, ecyc);
        issue(3'd4, 32'd0, 32'd0, cyc, st);
        model(3'd5, 32'hFFFFFFFF, 32'd0, ecyc);
        issue(3'd5, 32'hFFFFFFFF, 32'd0, cyc, st);
        model(3'd7, 32'd1, 32'd1, ecyc);
        issue(3'd7, 32'd1, 32'd1, cyc, st);
`ifdef MDU_MADD_EN
        tests++;
        if (cyc !== MC || HI !== 32'd1 || LO !== 32'd0) begin
            fails++;
            $display("FAIL maddu_carry: cyc=%0d HI=%h LO=%h, expected %0d 00000001 00000000", cyc, HI, LO, MC);
        end
`else
        tests++;
        if (cyc !== 0 || HI !== 32'd0 || LO !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL maddu_noop: cyc=%0d HI=%h LO=%h, expected 0 00000000 ffffffff", cyc, HI, LO);
        end
`endif
        model(3'd6, 32'hFFFFFFFD, 32'd7, ecyc);
        issue(3'd6, 32'hFFFFFFFD, 32'd7, cyc, st);
        tests++;
        if (cyc !== ecyc || HI !== m_hi || LO !== m_lo) begin
            fails++;
            $display("FAIL madd: cyc=%0d HI=%h LO=%h, expected %0d %h %h", cyc, HI, LO, ecyc, m_hi, m_lo);
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_random;
        test_start_while_busy;
        test_reset_mid_run;
        test_madd;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
